mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Single-port memory controller between the 8-bit unified RAM bus and two clients.
- Instruction side: the i-cache/fetch stage issues 64-byte block refill requests and receives a 512-bit block.
- Data side: the load/store buffer (LSB) issues 1/2/4-byte loads and stores.
- The block serialises every access into byte transactions, assembles and scatters data, and arbitrates between the clients. It sits directly upstream of the fetch stage's refill port.

Parameters:
BLK_BYTES, 64, bytes per i-cache block; the block port is 8*BLK_BYTES bits wide.
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; when low, all state is frozen and mem_wr is forced to 0
rollback  in  1  mispredict flush
io_buffer_full  in  1  UART buffer full
mem_din  in  8  RAM read data, valid one cycle after its address
mem_dout  out  8  RAM write data
mem_a  out  32  RAM byte address
mem_wr  out  1  RAM write strobe (1 = write)
if_valid  in  1  block request; held high until if_data_valid is seen
if_addr  in  32  block base address; bits [5:0] are 000000 or 000010, used as given
if_data_valid  out  1  one-cycle pulse: block ready
if_data  out  512  block data; byte i = mem[if_addr+i] at bits [8i+7:8i]
lsb_valid  in  1  data request; held until lsb_done
lsb_wr  in  1  1 = store
lsb_addr  in  32  byte address
lsb_size  in  2  00 = byte, 01 = half, 10 = word (11 is illegal and treated as word)
lsb_wdata  in  32  store data, little-endian
lsb_done  out  1  one-cycle pulse: access complete
lsb_rdata  out  32  load data, zero-extended, valid while lsb_done is high

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0.
  - All outputs are 0: mem_a, mem_dout, mem_wr, if_data_valid, lsb_done, lsb_rdata.
  - if_data is cleared to 0.
- States: IDLE, IFETCH, LOAD, STORE, TURN. All outputs are registered.
- Arbitration in IDLE (cycle A):
  - If lsb_valid is high and the access is not (store && addr[17:16]==IO_ADDR_HI && io_buffer_full), go to LOAD or STORE.
  - Otherwise, if if_valid is high, go to IFETCH.
  - LSB has priority. A blocked IO store does not block an ifetch behind it.
- Byte sequencing: let n = 1, 2, 4 (LSB) or BLK_BYTES (IFETCH). mem_a = base+i during cycle A+1+i, for i = 0..n-1.
- Reads:
  - The byte for address i is captured at the end of cycle A+2+i.
  - mem_a may keep advancing past the last byte; extra reads are harmless. mem_wr stays 0.
- IFETCH:
  - if_data_valid is high in cycle A+n+2 only, i.e. A+66 for a 64-byte block.
  - if_data holds its value until the next block completes.
- LOAD: lsb_done and lsb_rdata are valid in cycle A+n+2.
- STORE:
  - mem_wr=1 and mem_dout=lsb_wdata byte i during cycle A+1+i.
  - lsb_done is high in cycle A+n+1.
  - mem_wr returns to 0 the cycle after the last byte.
- Completion:
  - The cycle in which a done/valid pulse is high, the state is TURN. TURN lasts exactly one cycle, and no request is accepted in it (clients are still dropping valid).
  - The next state after TURN is IDLE.
- Rollback:
  - A LOAD in progress is aborted: no lsb_done is pulsed, and the state goes to TURN.
  - IFETCH and STORE are never aborted, because the fetch stage waits for its block and stores are committed.
  - A rollback seen in IDLE blocks acceptance of an LSB request in that same cycle.
- rdy low: state, counters and outputs hold, except mem_wr, which is driven 0. The byte index does not advance. Data for a read address presented before the stall is re-read after the stall.
- Address wrap: base+i uses 32-bit wraparound.

Decomposition:
- const.v gains:
  - MEM_IDLE, MEM_IFETCH, MEM_LOAD, MEM_STORE, MEM_TURN;
  - LSB_SIZE_B, LSB_SIZE_H, LSB_SIZE_W;
  - IO_ADDR_RANGE [17:16].
- The existing CACHE_BLK_MAXLEN macro sizes if_data.
- No sub-module: one FSM plus a byte counter and a shift-in register.

Test Plan:
1. if_valid=1, if_addr=0x1000, RAM[0x1000+i]=i -> mem_a steps 0x1000..0x103F in cycles A+1..A+64; if_data_valid is high only in A+66; if_data[7:0]=0x00 and if_data[511:504]=0x3F.
2. lsb_valid and if_valid rise together; load word at 0x2000 holding 0xDEADBEEF -> lsb_done in A+6 with lsb_rdata=0xDEADBEEF; TURN; ifetch is accepted in A+8.
3. Store half 0xABCD to 0x3001 -> mem_wr=1 with mem_a=0x3001/dout=0xCD, then mem_a=0x3002/dout=0xAB; lsb_done in A+3; RAM shows 0xCD, 0xAB.
4. Store byte to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr while full; accepted the cycle after full drops.
5. Load word in progress, rollback at A+3 -> no lsb_done; mem_wr stays 0; IDLE at A+5. Ifetch with rollback mid-transfer still completes at A+66.
6. Ifetch with rdy low for 3 cycles at A+10 -> mem_a frozen; if_data_valid in A+69; data matches RAM.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the unified-RAM memory controller.
package mem_ctrl_pkg;

  localparam int unsigned CACHE_BLK_BYTES  = 64;
  localparam int unsigned CACHE_BLK_MAXLEN = 8 * CACHE_BLK_BYTES;

  localparam logic [1:0] IO_ADDR_RANGE = 2'b11;

  localparam logic [1:0] LSB_SIZE_B = 2'b00;
  localparam logic [1:0] LSB_SIZE_H = 2'b01;
  localparam logic [1:0] LSB_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    MemIdle,
    MemIfetch,
    MemLoad,
    MemStore,
    MemTurn
  } mem_state_e;

  // Index of the last byte of an LSB access; the illegal size 11 behaves as a word.
  function automatic logic [1:0] lsb_last_idx(input logic [1:0] size);
    case (size)
      LSB_SIZE_B: return 2'd0;
      LSB_SIZE_H: return 2'd1;
      LSB_SIZE_W: return 2'd3;
      default:    return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller arbitrating i-cache block refills and LSB loads/stores
// onto the 8-bit unified RAM bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BLK_BYTES  = CACHE_BLK_BYTES,
  parameter logic [1:0]  IO_ADDR_HI = IO_ADDR_RANGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   io_buffer_full,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   if_valid,
  input  logic [31:0]            if_addr,
  output logic                   if_data_valid,
  output logic [8*BLK_BYTES-1:0] if_data,
  input  logic                   lsb_valid,
  input  logic                   lsb_wr,
  input  logic [31:0]            lsb_addr,
  input  logic [1:0]             lsb_size,
  input  logic [31:0]            lsb_wdata,
  output logic                   lsb_done,
  output logic [31:0]            lsb_rdata
);

  localparam int unsigned BW = 8 * BLK_BYTES;
  localparam int unsigned CW = $clog2(BLK_BYTES);

  mem_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cap_q, cap_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      ld_q, ld_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [31:0]      mem_a_q, mem_a_d;
  logic [7:0]       mem_dout_q, mem_dout_d;
  logic             wr_q, wr_d;
  logic [BW-1:0]    if_data_q, if_data_d;
  logic             if_dv_q, if_dv_d;
  logic             lsb_done_q, lsb_done_d;
  logic [31:0]      lsb_rdata_q, lsb_rdata_d;

  logic             io_block;
  logic [CW-1:0]    last_idx;
  logic [1:0]       nb;

  assign io_block = lsb_wr && (lsb_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    ld_d        = ld_q;
    blk_d       = blk_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    wr_d        = wr_q;
    if_data_d   = if_data_q;
    if_dv_d     = if_dv_q;
    lsb_done_d  = lsb_done_q;
    lsb_rdata_d = lsb_rdata_q;
    nb          = cnt_q[1:0] + 2'd1;
    last_idx    = (state_q == MemIfetch) ? CW'(BLK_BYTES - 1) : CW'(lsb_last_idx(size_q));

    unique case (state_q)
      MemIdle: begin
        if (lsb_valid && !rollback && !io_block) begin
          mem_a_d = lsb_addr;
          cnt_d   = '0;
          cap_d   = 1'b0;
          size_d  = lsb_size;
          wdata_d = lsb_wdata;
          ld_d    = '0;
          if (lsb_wr) begin
            state_d    = MemStore;
            wr_d       = 1'b1;
            mem_dout_d = lsb_wdata[7:0];
          end else begin
            state_d = MemLoad;
          end
        end else if (if_valid) begin
          state_d = MemIfetch;
          mem_a_d = if_addr;
          cnt_d   = '0;
          cap_d   = 1'b0;
        end
      end

      MemIfetch, MemLoad: begin
        // Address runs one cycle ahead of the returning byte; cap_q marks valid mem_din.
        mem_a_d = mem_a_q + 32'd1;
        cap_d   = 1'b1;
        if (state_q == MemLoad && rollback) begin
          state_d = MemTurn;
        end else if (cap_q) begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == MemIfetch) begin
            blk_d = {mem_din, blk_q[BW-1:8]};
          end else begin
            ld_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == last_idx) begin
            state_d = MemTurn;
            if (state_q == MemIfetch) begin
              if_dv_d   = 1'b1;
              if_data_d = blk_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = ld_d;
            end
          end
        end
      end

      MemStore: begin
        if (cnt_q == last_idx) begin
          wr_d       = 1'b0;
          lsb_done_d = 1'b1;
          state_d    = MemTurn;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          mem_a_d    = mem_a_q + 32'd1;
          mem_dout_d = wdata_q[{nb, 3'b000} +: 8];
        end
      end

      MemTurn: begin
        if_dv_d    = 1'b0;
        lsb_done_d = 1'b0;
        state_d    = MemIdle;
      end

      default: state_d = MemIdle;
    endcase
  end

  // rdy low freezes everything; only the write strobe is gated combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MemIdle;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      ld_q        <= '0;
      blk_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      wr_q        <= 1'b0;
      if_data_q   <= '0;
      if_dv_q     <= 1'b0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      ld_q        <= ld_d;
      blk_q       <= blk_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      wr_q        <= wr_d;
      if_data_q   <= if_data_d;
      if_dv_q     <= if_dv_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = wr_q & rdy;
  assign if_data       = if_data_q;
  assign if_data_valid = if_dv_q;
  assign lsb_done      = lsb_done_q;
  assign lsb_rdata     = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model whose read port stalls with rdy.
module tb_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback, io_buffer_full;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         if_valid;
  logic [31:0]  if_addr;
  logic         if_data_valid;
  logic [511:0] if_data;
  logic         lsb_valid, lsb_wr;
  logic [31:0]  lsb_addr;
  logic [1:0]   lsb_size;
  logic [31:0]  lsb_wdata;
  logic         lsb_done;
  logic [31:0]  lsb_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram     [0:262143];
  bit         written [0:262143];

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_data_valid  (if_data_valid),
    .if_data        (if_data),
    .lsb_valid      (lsb_valid),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_size       (lsb_size),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata)
  );

  always #5 clk = ~clk;

  // Untouched bytes read as addr[7:0], except the DEADBEEF word at 0x2000.
  function automatic logic [7:0] ram_init(input logic [31:0] a);
    case (a)
      32'h2000: return 8'hEF;
      32'h2001: return 8'hBE;
      32'h2002: return 8'hAD;
      32'h2003: return 8'hDE;
      default:  return a[7:0];
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return written[a[17:0]] ? ram[a[17:0]] : ram_init(a);
  endfunction

  always @(posedge clk) begin
    if (rdy) mem_din <= ram_rd(mem_a);
    if (mem_wr) begin
      ram[mem_a[17:0]]     <= mem_dout;
      written[mem_a[17:0]] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL rst_mem_dout: got %h want 0", mem_dout); end
    checks++; if (if_data_valid !== 1'b0) begin errors++; $display("FAIL rst_if_dv: got %b want 0", if_data_valid); end
    checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL rst_lsb_done: got %b want 0", lsb_done); end
    checks++; if (lsb_rdata !== 32'h0) begin errors++; $display("FAIL rst_lsb_rdata: got %h want 0", lsb_rdata); end
    checks++; if (if_data !== 512'h0) begin errors++; $display("FAIL rst_if_data: got nonzero %h", if_data[63:0]); end
    rst = 1'b0;
    tick();
    if_valid = 1'b1; if_addr = 32'h1000;
    tick();
    tick();
    checks++; if (mem_a !== 32'h1001) begin errors++; $display("FAIL pre_async_mem_a: got %h want 00001001", mem_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL async_rst_mem_a: got %h want 0", mem_a); end
    if_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifetch();
    logic [511:0] exp;
    for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'(i);
    if_valid = 1'b1; if_addr = 32'h1000;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k <= 64) begin
        checks++;
        if (mem_a !== 32'h1000 + 32'(k - 1)) begin
          errors++; $display("FAIL ifetch_addr A+%0d: got %h want %h", k, mem_a, 32'h1000 + 32'(k - 1));
        end
      end
      checks++;
      if (if_data_valid !== (k == 66)) begin
        errors++; $display("FAIL ifetch_valid A+%0d: got %b want %b", k, if_data_valid, k == 66);
      end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL ifetch_wr A+%0d: got %b want 0", k, mem_wr); end
      if (if_data_valid) if_valid = 1'b0;
    end
    checks++; if (if_data !== exp) begin errors++; $display("FAIL ifetch_data: got %h want %h", if_data, exp); end
    tick();
    checks++; if (if_data_valid !== 1'b0) begin errors++; $display("FAIL ifetch_pulse: got %b want 0", if_data_valid); end
    checks++; if (if_data !== exp) begin errors++; $display("FAIL ifetch_hold: got %h want %h", if_data, exp); end
  endtask

  task automatic test_priority();
    lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_size = 2'b10;
    if_valid = 1'b1; if_addr = 32'h1040;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (mem_a !== 32'h2000) begin errors++; $display("FAIL prio_addr: got %h want 00002000", mem_a); end
      end
      checks++;
      if (lsb_done !== (k == 6)) begin errors++; $display("FAIL prio_done A+%0d: got %b want %b", k, lsb_done, k == 6); end
      checks++; if (if_data_valid !== 1'b0) begin errors++; $display("FAIL prio_ifdv A+%0d: got 1 want 0", k); end
      if (k == 6) begin
        checks++;
        if (lsb_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_rdata: got %h want deadbeef", lsb_rdata); end
        lsb_valid = 1'b0;
      end
      if (k == 8) begin
        checks++; if (mem_a !== 32'h1040) begin errors++; $display("FAIL prio_ifetch_addr: got %h want 00001040", mem_a); end
      end
    end
    for (int n = 0; n < 80 && !if_data_valid; n++) tick();
    checks++; if (if_data_valid !== 1'b1) begin errors++; $display("FAIL prio_ifetch_timeout: got %b want 1", if_data_valid); end
    checks++; if (if_data[7:0] !== 8'h40) begin errors++; $display("FAIL prio_byte0: got %h want 40", if_data[7:0]); end
    checks++; if (if_data[511:504] !== 8'h7F) begin errors++; $display("FAIL prio_byte63: got %h want 7f", if_data[511:504]); end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_store();
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h3001; lsb_size = 2'b01; lsb_wdata = 32'h0000ABCD;
    tick();
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h3001, 8'hCD}) begin
      errors++; $display("FAIL st_byte0: got wr=%b a=%h d=%h want 1/00003001/cd", mem_wr, mem_a, mem_dout);
    end
    tick();
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h3002, 8'hAB}) begin
      errors++; $display("FAIL st_byte1: got wr=%b a=%h d=%h want 1/00003002/ab", mem_wr, mem_a, mem_dout);
    end
    checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL st_early_done: got 1 want 0"); end
    tick();
    checks++;
    if ({lsb_done, mem_wr} !== 2'b10) begin errors++; $display("FAIL st_done: got done=%b wr=%b want 1/0", lsb_done, mem_wr); end
    lsb_valid = 1'b0;
    tick();
    checks++;
    if ({ram_rd(32'h3001), ram_rd(32'h3002), ram_rd(32'h3003)} !== 24'hCDAB03) begin
      errors++; $display("FAIL st_ram: got %h %h %h want cd ab 03", ram_rd(32'h3001), ram_rd(32'h3002), ram_rd(32'h3003));
    end
    lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h3001; lsb_size = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (lsb_done !== (k == 4)) begin errors++; $display("FAIL ldh_done A+%0d: got %b want %b", k, lsb_done, k == 4); end
    end
    checks++; if (lsb_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL ldh_rdata: got %h want 0000abcd", lsb_rdata); end
    lsb_addr = 32'h3002; lsb_size = 2'b00;
    tick();
    for (int k = 1; k <= 3; k++) tick();
    checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL ldb_done: got %b want 1", lsb_done); end
    checks++; if (lsb_rdata !== 32'h000000AB) begin errors++; $display("FAIL ldb_rdata: got %h want 000000ab", lsb_rdata); end
    lsb_valid = 1'b0;
    tick();
  endtask

  task automatic test_io_block();
    io_buffer_full = 1'b1;
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_size = 2'b00; lsb_wdata = 32'h0000005A;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if ({mem_wr, lsb_done} !== 2'b00) begin errors++; $display("FAIL io_blocked A+%0d: got wr=%b done=%b want 0/0", k, mem_wr, lsb_done); end
    end
    io_buffer_full = 1'b0;
    tick();
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h5A}) begin
      errors++; $display("FAIL io_accept: got wr=%b a=%h d=%h want 1/00030000/5a", mem_wr, mem_a, mem_dout);
    end
    tick();
    checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL io_done: got %b want 1", lsb_done); end
    lsb_valid = 1'b0;
    tick();
    checks++; if (ram_rd(32'h30000) !== 8'h5A) begin errors++; $display("FAIL io_ram: got %h want 5a", ram_rd(32'h30000)); end
  endtask

  task automatic test_rollback();
    lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_size = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) begin rollback = 1'b1; lsb_valid = 1'b0; end
      if (k == 4) rollback = 1'b0;
      if (k == 5) begin if_valid = 1'b1; if_addr = 32'h1080; end
      checks++;
      if ({lsb_done, mem_wr} !== 2'b00) begin errors++; $display("FAIL rb_load A+%0d: got done=%b wr=%b want 0/0", k, lsb_done, mem_wr); end
    end
    for (int j = 1; j <= 66; j++) begin
      tick();
      if (j == 1) begin
        checks++; if (mem_a !== 32'h1080) begin errors++; $display("FAIL rb_idle_accept: got %h want 00001080", mem_a); end
      end
      if (j <= 3) begin
        checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL rb_late_done B+%0d: got 1 want 0", j); end
      end
      if (j == 20) rollback = 1'b1;
      if (j == 23) rollback = 1'b0;
      checks++;
      if (if_data_valid !== (j == 66)) begin errors++; $display("FAIL rb_ifetch_valid B+%0d: got %b want %b", j, if_data_valid, j == 66); end
      if (if_data_valid) if_valid = 1'b0;
    end
    checks++;
    if ({if_data[511:504], if_data[7:0]} !== 16'hBF80) begin
      errors++; $display("FAIL rb_ifetch_data: got %h..%h want bf..80", if_data[511:504], if_data[7:0]);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [511:0] exp;
    for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'(8'hC2 + i);
    if_valid = 1'b1; if_addr = 32'h40C2;
    for (int k = 1; k <= 69; k++) begin
      tick();
      if (k == 10) rdy = 1'b0;
      if (k == 13) rdy = 1'b1;
      if (k >= 11 && k <= 13) begin
        checks++; if (mem_a !== 32'h40CB) begin errors++; $display("FAIL stall_frozen A+%0d: got %h want 000040cb", k, mem_a); end
      end
      if (k == 14) begin
        checks++; if (mem_a !== 32'h40CC) begin errors++; $display("FAIL stall_resume: got %h want 000040cc", mem_a); end
      end
      checks++;
      if (if_data_valid !== (k == 69)) begin errors++; $display("FAIL stall_valid A+%0d: got %b want %b", k, if_data_valid, k == 69); end
      if (if_data_valid) if_valid = 1'b0;
    end
    checks++; if (if_data !== exp) begin errors++; $display("FAIL stall_data: got %h want %h", if_data, exp); end
    tick();
  endtask

  task automatic test_store_wrap();
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'hFFFFFFFE; lsb_size = 2'b10; lsb_wdata = 32'h44332211;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) begin
        rdy = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL wrap_stall_wr: got %b want 0", mem_wr); end
      end
      if (k == 3) begin rdy = 1'b1; #1; end
      if (k == 1 || k == 3 || k == 4 || k == 5) begin
        checks++;
        case (k)
          1: if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'hFFFFFFFE, 8'h11}) begin
               errors++; $display("FAIL wrap_b0: got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout); end
          3: if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'hFFFFFFFF, 8'h22}) begin
               errors++; $display("FAIL wrap_b1: got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout); end
          4: if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h00000000, 8'h33}) begin
               errors++; $display("FAIL wrap_b2: got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout); end
          default: if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h00000001, 8'h44}) begin
               errors++; $display("FAIL wrap_b3: got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout); end
        endcase
      end
      checks++;
      if (lsb_done !== (k == 6)) begin errors++; $display("FAIL wrap_done A+%0d: got %b want %b", k, lsb_done, k == 6); end
    end
    lsb_valid = 1'b0;
    tick();
    checks++;
    if ({ram_rd(32'hFFFFFFFE), ram_rd(32'hFFFFFFFF), ram_rd(32'h0), ram_rd(32'h1)} !== 32'h11223344) begin
      errors++; $display("FAIL wrap_ram: got %h %h %h %h want 11 22 33 44",
                         ram_rd(32'hFFFFFFFE), ram_rd(32'hFFFFFFFF), ram_rd(32'h0), ram_rd(32'h1));
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_valid = 1'b0; if_addr = '0;
    lsb_valid = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
    test_reset();
    test_ifetch();
    test_priority();
    test_store();
    test_io_block();
    test_rollback();
    test_stall();
    test_store_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
